// File: rtl/cp0_mmu_ctrl.sv
// cp0_mmu_ctrl: CP0 privileged register file at WB.
//  Handles exception/ERET commit and fetch redirect, the Count/Compare timer,
//  hardware and software interrupt requests, and tlbr/tlbwi/tlbwr/tlbp.
// Ports:
//  clk, resetn            clock, synchronous active-low reset
//  wb_valid, wb_cancel    commit = wb_valid & ~wb_cancel
//  mtc0_we/cp0_addr/mtc0_wdata, cp0_rdata   MTC0 write / MFC0 read ({rd,sel})
//  exc, exc_code, exc_bd, exc_pc, exc_badvaddr, eret   exception/ERET at WB
//  tlbr/tlbwi/tlbwr/tlbp, s_found/s_index, r_index/r_entry, w_en/w_index/w_entry
//  hw_int, int_req        level interrupts in, pending-interrupt request out
//  flush, flush_pc        fetch redirect
//  entryhi_o              EntryHi (current ASID) for the MMU
// Build option: define CP0_RANDOM_EN for a live Random/Wired pair; otherwise
// both read 0 and tlbwr uses Index like tlbwi.
module cp0_mmu_ctrl #(
  parameter int          TLBNUM     = 16,
  parameter int          HW_INT_NUM = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VEC    = 32'hBFC00380,
  parameter logic [31:0] REFILL_VEC = 32'hBFC00200,
  localparam int         IDXW       = $clog2(TLBNUM)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wb_valid,
  input  logic                  wb_cancel,
  input  logic                  mtc0_we,
  input  logic [7:0]            cp0_addr,
  input  logic [31:0]           mtc0_wdata,
  output logic [31:0]           cp0_rdata,
  input  logic                  exc,
  input  logic [4:0]            exc_code,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_pc,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  input  logic                  tlbr,
  input  logic                  tlbwi,
  input  logic                  tlbwr,
  input  logic                  tlbp,
  input  logic                  s_found,
  input  logic [IDXW-1:0]       s_index,
  output logic [IDXW-1:0]       r_index,
  input  logic [77:0]           r_entry,
  output logic                  w_en,
  output logic [IDXW-1:0]       w_index,
  output logic [77:0]           w_entry,
  input  logic [HW_INT_NUM-1:0] hw_int,
  output logic                  int_req,
  output logic                  flush,
  output logic [31:0]           flush_pc,
  output logic [31:0]           entryhi_o
);
  localparam logic [7:0] A_INDEX = 8'h00, A_RANDOM = 8'h08, A_LO0 = 8'h10, A_LO1 = 8'h18,
                         A_WIRED = 8'h30, A_BADV = 8'h40, A_COUNT = 8'h48, A_HI = 8'h50,
                         A_CMP = 8'h58, A_STATUS = 8'h60, A_CAUSE = 8'h68, A_EPC = 8'h70;
  localparam logic [31:0]     PRE_MAX  = 32'(COUNT_DIV - 1);
  localparam logic [IDXW-1:0] RAND_MAX = IDXW'(TLBNUM - 1);

  logic            idx_p;
  logic [IDXW-1:0] idx;
  logic [25:0]     lo0, lo1;          // {pfn[19:0], c[2:0], d, v, g}
  logic [18:0]     hi_vpn2;
  logic [7:0]      hi_asid;
  logic [31:0]     badv, count, compare, epc, pre;
  logic [7:0]      im;
  logic            exl, ie, bd, ti;
  logic [5:0]      ip_hw;             // IP[7:2]
  logic [1:0]      ip_sw;             // IP[1:0]
  logic [4:0]      exccode;
  logic [IDXW-1:0] random_q, wired_q;
  logic [5:0]      hw6;

  logic commit, tlb_any, do_exc, do_eret, do_tlb, do_mtc0, refill;
  assign commit  = wb_valid & ~wb_cancel;
  assign tlb_any = tlbr | tlbwi | tlbwr | tlbp;
  // Priority exc > eret > tlb* > mtc0 when more than one is raised.
  assign do_exc  = commit & exc;
  assign do_eret = commit & eret & ~exc;
  assign do_tlb  = commit & ~exc & ~eret;
  assign do_mtc0 = commit & mtc0_we & ~exc & ~eret & ~tlb_any;
  assign refill  = ((exc_code == 5'd2) || (exc_code == 5'd3)) & ~exl;
  assign hw6     = 6'(hw_int);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx_p <= 1'b0; idx <= '0; lo0 <= '0; lo1 <= '0; hi_vpn2 <= '0; hi_asid <= '0;
      badv <= '0; epc <= '0; count <= '0; pre <= '0;
      compare <= '1;                  // keeps TI quiet straight out of reset
      im <= '0; exl <= 1'b0; ie <= 1'b0;
      bd <= 1'b0; ti <= 1'b0; ip_hw <= '0; ip_sw <= '0; exccode <= '0;
    end else begin
      // Timer runs regardless of commit.
      if (do_mtc0 && cp0_addr == A_COUNT) begin
        count <= mtc0_wdata; pre <= '0;
      end else if (pre == PRE_MAX) begin
        count <= count + 32'd1; pre <= '0;
      end else begin
        pre <= pre + 32'd1;
      end
      if (do_mtc0 && cp0_addr == A_CMP) begin
        compare <= mtc0_wdata; ti <= 1'b0;   // clear beats a simultaneous match
      end else if (count == compare) begin
        ti <= 1'b1;
      end
      ip_hw <= {ti | hw6[5], hw6[4:0]};

      if (do_exc) begin
        exl     <= 1'b1;
        exccode <= exc_code;
        if (!exl) begin
          epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
          bd  <= exc_bd;
        end
        if (exc_code >= 5'd1 && exc_code <= 5'd5) badv <= exc_badvaddr;
        if (exc_code >= 5'd1 && exc_code <= 5'd3) hi_vpn2 <= exc_badvaddr[31:13];
      end
      if (do_eret) exl <= 1'b0;

      if (do_tlb && tlbp) begin
        idx_p <= ~s_found; idx <= s_index;
      end
      if (do_tlb && tlbr) begin
        hi_vpn2 <= r_entry[77:59];
        hi_asid <= r_entry[58:51];
        lo0     <= {r_entry[49:25], r_entry[50]};
        lo1     <= {r_entry[24:0],  r_entry[50]};
      end

      if (do_mtc0) begin
        case (cp0_addr)
          A_INDEX:  idx <= mtc0_wdata[IDXW-1:0];
          A_LO0:    lo0 <= mtc0_wdata[25:0];
          A_LO1:    lo1 <= mtc0_wdata[25:0];
          A_HI:     begin hi_vpn2 <= mtc0_wdata[31:13]; hi_asid <= mtc0_wdata[7:0]; end
          A_STATUS: begin im <= mtc0_wdata[15:8]; exl <= mtc0_wdata[1]; ie <= mtc0_wdata[0]; end
          A_CAUSE:  ip_sw <= mtc0_wdata[9:8];
          A_EPC:    epc <= mtc0_wdata;
          default:  ;
        endcase
      end
    end
  end

`ifdef CP0_RANDOM_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      random_q <= RAND_MAX; wired_q <= '0;
    end else if (do_mtc0 && cp0_addr == A_WIRED) begin
      wired_q  <= (mtc0_wdata >= 32'(TLBNUM)) ? RAND_MAX : mtc0_wdata[IDXW-1:0];
      random_q <= RAND_MAX;
    end else begin
      random_q <= (random_q == wired_q) ? RAND_MAX : random_q - 1'b1;
    end
  end
  assign w_index = tlbwr ? random_q : idx;
`else
  assign random_q = '0;
  assign wired_q  = '0;
  assign w_index  = idx;
`endif

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      A_INDEX:  cp0_rdata = {idx_p, {(31-IDXW){1'b0}}, idx};
      A_RANDOM: cp0_rdata = 32'(random_q);
      A_LO0:    cp0_rdata = {6'b0, lo0};
      A_LO1:    cp0_rdata = {6'b0, lo1};
      A_WIRED:  cp0_rdata = 32'(wired_q);
      A_BADV:   cp0_rdata = badv;
      A_COUNT:  cp0_rdata = count;
      A_HI:     cp0_rdata = {hi_vpn2, 5'b0, hi_asid};
      A_CMP:    cp0_rdata = compare;
      A_STATUS: cp0_rdata = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
      A_CAUSE:  cp0_rdata = {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exccode, 2'b0};
      A_EPC:    cp0_rdata = epc;
      default:  cp0_rdata = '0;
    endcase
  end

  assign r_index   = idx;
  assign w_en      = resetn & do_tlb & (tlbwi | tlbwr);
  assign w_entry   = {hi_vpn2, hi_asid, lo0[0] & lo1[0], lo0[25:1], lo1[25:1]};
  assign int_req   = resetn & ie & ~exl & |({ip_hw, ip_sw} & im);
  assign flush     = resetn & (do_exc | do_eret);
  assign flush_pc  = exc ? (refill ? REFILL_VEC : EXC_VEC) : epc;
  assign entryhi_o = {hi_vpn2, 5'b0, hi_asid};
endmodule

// File: tb/tb_cp0_mmu_ctrl.sv
// Bench for cp0_mmu_ctrl: register write/read table, then hand sequences for
// exceptions, timer interrupt, TLB ops, Random/Wired and mid-operation reset.
module tb_cp0_mmu_ctrl;
  localparam int IDXW = 4;
  logic clk = 1'b0, resetn = 1'b0;
  logic wb_valid, wb_cancel, mtc0_we, exc, exc_bd, eret, tlbr, tlbwi, tlbwr, tlbp, s_found;
  logic [7:0] cp0_addr;
  logic [31:0] mtc0_wdata, cp0_rdata, exc_pc, exc_badvaddr, flush_pc, entryhi_o;
  logic [4:0] exc_code;
  logic [IDXW-1:0] s_index, r_index, w_index;
  logic [77:0] r_entry, w_entry;
  logic w_en, int_req, flush;
  logic [5:0] hw_int;

  always #5 clk = ~clk;

  cp0_mmu_ctrl dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_cancel(wb_cancel),
    .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .mtc0_wdata(mtc0_wdata), .cp0_rdata(cp0_rdata),
    .exc(exc), .exc_code(exc_code), .exc_bd(exc_bd), .exc_pc(exc_pc),
    .exc_badvaddr(exc_badvaddr), .eret(eret), .tlbr(tlbr), .tlbwi(tlbwi), .tlbwr(tlbwr),
    .tlbp(tlbp), .s_found(s_found), .s_index(s_index), .r_index(r_index), .r_entry(r_entry),
    .w_en(w_en), .w_index(w_index), .w_entry(w_entry), .hw_int(hw_int), .int_req(int_req),
    .flush(flush), .flush_pc(flush_pc), .entryhi_o(entryhi_o));

  typedef struct { string name; logic [77:0] exp; } sb_t;
  typedef struct { string name; logic [7:0] addr; logic [31:0] wdata; logic [31:0] exp; } vec_t;
  sb_t  sbq[$];
  vec_t tbl[15];
  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [77:0] act, input logic [77:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [77:0] e);
    sb_t s;
    s.name = nm; s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic pop_chk(input logic [77:0] act);
    sb_t s;
    if (sbq.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_empty: got %0h expected nothing", act);
    end else begin
      s = sbq.pop_front();
      chk(s.name, act, s.exp);
    end
  endtask

  task automatic clr();
    wb_valid = 0; wb_cancel = 0; mtc0_we = 0; exc = 0; eret = 0; exc_bd = 0;
    tlbr = 0; tlbwi = 0; tlbwr = 0; tlbp = 0; s_found = 0; s_index = '0;
    exc_code = '0; exc_pc = '0; exc_badvaddr = '0; mtc0_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1; clr();
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_valid = 1; mtc0_we = 1; cp0_addr = a; mtc0_wdata = d;
    tick();
  endtask

  task automatic rd(input string nm, input logic [7:0] a, input logic [31:0] e);
    @(negedge clk);
    cp0_addr = a; push(nm, 78'(e));
    #1 pop_chk(78'(cp0_rdata));
  endtask

  task automatic excp(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                      input logic [31:0] bad, input logic cancel,
                      input logic exp_fl, input logic [31:0] exp_pc);
    @(negedge clk);
    wb_valid = 1; wb_cancel = cancel; exc = 1; exc_code = code; exc_bd = bd;
    exc_pc = pc; exc_badvaddr = bad;
    push("exc_flush", 78'(exp_fl)); push("exc_flush_pc", 78'(exp_pc));
    #1 pop_chk(78'(flush)); pop_chk(78'(flush_pc));
    tick();
  endtask

  task automatic eret_go(input logic [31:0] exp_pc);
    @(negedge clk);
    wb_valid = 1; eret = 1;
    push("eret_flush", 78'(1)); push("eret_flush_pc", 78'(exp_pc));
    #1 pop_chk(78'(flush)); pop_chk(78'(flush_pc));
    tick();
  endtask

  task automatic at_neg_chk(input string nm, input logic [77:0] act_now, input logic [77:0] e);
    push(nm, e);
    pop_chk(act_now);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] exp_rand;
    logic [77:0] exp_we;
    tbl[0]  = '{"index_mask",   8'h00, 32'hFFFFFFFF, 32'h0000000F};
    tbl[1]  = '{"lo0_mask",     8'h10, 32'hFFFFFFFF, 32'h03FFFFFF};
    tbl[2]  = '{"lo1_mask",     8'h18, 32'h12345678, 32'h02345678};
    tbl[3]  = '{"entryhi_mask", 8'h50, 32'hFFFFFFFF, 32'hFFFFE0FF};
    tbl[4]  = '{"status_all",   8'h60, 32'hFFFFFFFF, 32'h0040FF03};
    tbl[5]  = '{"cause_sw",     8'h68, 32'hFFFFFFFF, 32'h00000300};
    tbl[6]  = '{"cause_clr",    8'h68, 32'h00000000, 32'h00000000};
    tbl[7]  = '{"status_im",    8'h60, 32'h0000FF00, 32'h0040FF00};
    tbl[8]  = '{"status_clr",   8'h60, 32'h00000000, 32'h00400000};
    tbl[9]  = '{"epc_rw",       8'h70, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[10] = '{"badv_ro",      8'h40, 32'h00001234, 32'h00000000};
    tbl[11] = '{"compare_rw",   8'h58, 32'hFFFF0000, 32'hFFFF0000};
`ifdef CP0_RANDOM_EN
    tbl[12] = '{"wired_rw",     8'h30, 32'h00000005, 32'h00000005};
`else
    tbl[12] = '{"wired_off",    8'h30, 32'h00000005, 32'h00000000};
`endif
    tbl[13] = '{"unimpl_sel1",  8'h61, 32'hFFFFFFFF, 32'h00000000};
    tbl[14] = '{"unimpl_r15",   8'h78, 32'hFFFFFFFF, 32'h00000000};

    clr(); cp0_addr = '0; hw_int = '0; r_entry = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    // Reset state, sampled before any post-reset edge.
`ifdef CP0_RANDOM_EN
    exp_rand = 32'd15;
`else
    exp_rand = 32'd0;
`endif
    cp0_addr = 8'h08; #1 at_neg_chk("rst_random", 78'(cp0_rdata), 78'(exp_rand));
    cp0_addr = 8'h48; #1 at_neg_chk("rst_count", 78'(cp0_rdata), 78'(0));
    chk("rst_outs", {75'b0, flush, w_en, int_req}, 78'(0));
    rd("rst_status", 8'h60, 32'h00400000);
    rd("rst_cause",  8'h68, 32'h00000000);
    rd("rst_index",  8'h00, 32'h00000000);

    for (int i = 0; i < 15; i++) begin
      mtc0(tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].name, tbl[i].addr, tbl[i].exp);
    end

    // Count load clears the prescaler; increments every second edge.
    mtc0(8'h48, 32'd100);
    rd("count_load", 8'h48, 32'd100);
    rd("count_pre",  8'h48, 32'd100);
    rd("count_inc",  8'h48, 32'd101);

    // Software interrupt, then masked by EXL.
    mtc0(8'h60, 32'h00000101);
    mtc0(8'h68, 32'h00000100);
    @(negedge clk); #1 at_neg_chk("sw_int", 78'(int_req), 78'(1));
    mtc0(8'h60, 32'h00000103);
    @(negedge clk); #1 at_neg_chk("sw_int_exl", 78'(int_req), 78'(0));
    mtc0(8'h68, 32'h0);
    // Hardware interrupt line with one cycle of latency.
    mtc0(8'h60, 32'h00000401);
    @(negedge clk); hw_int = 6'b000001;
    #1 at_neg_chk("hw_int_lat", 78'(int_req), 78'(0));
    @(negedge clk); #1 at_neg_chk("hw_int", 78'(int_req), 78'(1));
    hw_int = '0;
    mtc0(8'h60, 32'h0);

    // Exception in a delay slot, nested exception, ERET.
    excp(5'd4, 1'b1, 32'h80001004, 32'h3, 1'b0, 1'b1, 32'hBFC00380);
    rd("exc_epc",    8'h70, 32'h80001000);
    rd("exc_cause",  8'h68, 32'h80000010);
    rd("exc_badv",   8'h40, 32'h00000003);
    rd("exc_status", 8'h60, 32'h00400002);
    excp(5'd5, 1'b0, 32'h90000000, 32'h77, 1'b0, 1'b1, 32'hBFC00380);
    rd("nest_epc",   8'h70, 32'h80001000);
    rd("nest_cause", 8'h68, 32'h80000014);
    rd("nest_badv",  8'h40, 32'h00000077);
    eret_go(32'h80001000);
    rd("eret_status", 8'h60, 32'h00400000);

    // Cancelled refill changes nothing; committed refill goes to REFILL_VEC.
    excp(5'd2, 1'b0, 32'h80002000, 32'h12346000, 1'b1, 1'b0, 32'hBFC00200);
    rd("cancel_cause",  8'h68, 32'h80000014);
    rd("cancel_status", 8'h60, 32'h00400000);
    rd("cancel_epc",    8'h70, 32'h80001000);
    rd("cancel_hi",     8'h50, 32'hFFFFE0FF);
    excp(5'd2, 1'b0, 32'h80002000, 32'h12346000, 1'b0, 1'b1, 32'hBFC00200);
    rd("refill_hi",    8'h50, 32'h123460FF);
    rd("refill_epc",   8'h70, 32'h80002000);
    rd("refill_cause", 8'h68, 32'h00000008);
    rd("refill_badv",  8'h40, 32'h12346000);
    chk("entryhi_o", 78'(entryhi_o), 78'(32'h123460FF));
    excp(5'd3, 1'b0, 32'h80003000, 32'h0, 1'b0, 1'b1, 32'hBFC00380);
    eret_go(32'h80002000);

    // Timer interrupt: Count 0 -> 5 takes 10 edges, TI one more, IP[7] one more.
    mtc0(8'h60, 32'h00008001);
    @(negedge clk); #1 at_neg_chk("timer_idle", 78'(int_req), 78'(0));
    mtc0(8'h58, 32'd5);
    mtc0(8'h48, 32'd0);
    n = 41;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (int_req) begin n = k; break; end
    end
    chk("timer_latency_ok", 78'(n >= 11 && n <= 13), 78'(1));
    if (n > 40) $display("FAIL timer_rise: got no int_req expected int_req within 40 cycles");
    @(negedge clk); cp0_addr = 8'h68; #1 at_neg_chk("timer_ti", 78'(cp0_rdata[30]), 78'(1));
    mtc0(8'h58, 32'hFFFF0000);
    @(negedge clk); cp0_addr = 8'h68; #1 at_neg_chk("ti_clr", 78'(cp0_rdata[30]), 78'(0));
    n = 5;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (!int_req) begin n = k; break; end
    end
    chk("timer_drop", 78'(n < 4), 78'(1));
    mtc0(8'h60, 32'h0);

    // TLB write, probe and read.
    mtc0(8'h10, 32'h02AF379F);
    mtc0(8'h18, 32'h0048D152);
    mtc0(8'h50, 32'h80002042);
    mtc0(8'h00, 32'd3);
    exp_we = {19'h40001, 8'h42, 1'b0, 20'hABCDE, 3'd3, 1'b1, 1'b1,
              20'h12345, 3'd2, 1'b0, 1'b1};
    @(negedge clk); wb_valid = 1; tlbwi = 1;
    push("tlbwi_wen", 78'(1)); push("tlbwi_idx", 78'(3)); push("tlbwi_entry", exp_we);
    #1 pop_chk(78'(w_en)); pop_chk(78'(w_index)); pop_chk(w_entry);
    tick();
    @(negedge clk); #1 at_neg_chk("wen_idle", 78'(w_en), 78'(0));
    wb_valid = 1; wb_cancel = 1; tlbwi = 1;
    #1 at_neg_chk("wen_cancel", 78'(w_en), 78'(0));
    tick();
`ifndef CP0_RANDOM_EN
    @(negedge clk); wb_valid = 1; tlbwr = 1;
    #1 at_neg_chk("tlbwr_wen", 78'(w_en), 78'(1));
    at_neg_chk("tlbwr_as_wi", 78'(w_index), 78'(3));
    tick();
`endif
    @(negedge clk); wb_valid = 1; tlbp = 1; s_found = 0; s_index = 4'd7;
    tick();
    rd("tlbp_miss", 8'h00, 32'h80000007);
    @(negedge clk); wb_valid = 1; tlbp = 1; s_found = 1; s_index = 4'd9;
    tick();
    rd("tlbp_hit", 8'h00, 32'h00000009);
    chk("r_index", 78'(r_index), 78'(9));
    @(negedge clk); wb_valid = 1; tlbr = 1;
    r_entry = {19'h7FFFF, 8'hA5, 1'b1, 20'h11111, 3'd5, 1'b1, 1'b0,
               20'h22222, 3'd1, 1'b0, 1'b1};
    tick();
    rd("tlbr_hi",  8'h50, 32'hFFFFE0A5);
    rd("tlbr_lo0", 8'h10, {6'b0, 20'h11111, 3'd5, 1'b1, 1'b0, 1'b1});
    rd("tlbr_lo1", 8'h18, {6'b0, 20'h22222, 3'd1, 1'b0, 1'b1, 1'b1});

    // Random/Wired.
`ifdef CP0_RANDOM_EN
    mtc0(8'h30, 32'd4);
    for (int k = 0; k < 13; k++) rd("random_seq", 8'h08, (k < 12) ? 32'(15 - k) : 32'd15);
    @(negedge clk); wb_valid = 1; tlbwr = 1;
    #1 at_neg_chk("tlbwr_random", 78'(w_index), 78'(14));
    tick();
    mtc0(8'h30, 32'd20);
    rd("wired_clamp", 8'h30, 32'd15);
    rd("random_rst",  8'h08, 32'd15);
`else
    mtc0(8'h30, 32'd4);
    rd("wired_off2",  8'h30, 32'd0);
    rd("random_off",  8'h08, 32'd0);
`endif

    // Reset asserted mid-operation.
    mtc0(8'h60, 32'h00000003);
    @(negedge clk); resetn = 0; wb_valid = 1; tlbwi = 1;
    #1 at_neg_chk("rst_wen", 78'(w_en), 78'(0));
    tlbwi = 0; exc = 1; exc_code = 5'd4;
    #1 at_neg_chk("rst_flush", 78'(flush), 78'(0));
    tick();
    @(negedge clk); resetn = 1;
    cp0_addr = 8'h60; #1 at_neg_chk("rst2_status", 78'(cp0_rdata), 78'(32'h00400000));
    cp0_addr = 8'h00; #1 at_neg_chk("rst2_index",  78'(cp0_rdata), 78'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
